// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-requester ROM arbiter.
//   - Default ROM geometry (address and word width).
//   - Arbiter state encoding (IDLE, READ, RESP) in 2 bits.
//   - Requester-id type (1 bit) and a helper that names the other requester.
package rom_arbiter_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_ID_0 = 1'b0;
    localparam req_id_t REQ_ID_1 = 1'b1;

    // The requester that did not win; the round-robin pointer moves here.
    function automatic req_id_t other_id(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/rom32x8.sv
// Synchronous-read ROM, entry[i] = (i + 1) mod 2^DATA_W.
// Ports:
//   clk      - clock
//   en       - read enable; data_out updates one cycle after en is sampled high
//   addr     - read address
//   data_out - registered read data; holds its value while en is low
// No reset: the contents are fixed and the output is only consumed after a read.
module rom32x8
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out
);

    // Registered read; the contents are generated from the address directly.
    always_ff @(posedge clk) begin
        if (en) begin
            data_out <= DATA_W'(addr) + DATA_W'(1'b1);
        end else begin
            data_out <= data_out;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter granting two requesters access to a shared ROM.
// Ports:
//   clk            - clock
//   rst            - synchronous active-high reset
//   req0, req1     - read requests, held until the matching gnt pulse
//   addr0, addr1   - read addresses, stable while the matching req is high
//   gnt0, gnt1     - one-cycle pulse: request and address accepted
//   rvalid0/1      - one-cycle pulse: rdata holds the word for that requester
//   rdata          - shared read data, holds its last value between responses
//   busy           - high whenever the arbiter is not in IDLE
// A transaction takes IDLE -> READ -> RESP, so at most one read per 3 cycles.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    state_t            state_r;
    state_t            state_next_s;
    req_id_t           id_r;
    req_id_t           id_next_s;
    req_id_t           ptr_r;
    req_id_t           ptr_next_s;
    req_id_t           win_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;

    logic              gnt0_r;
    logic              gnt1_r;
    logic              rvalid0_r;
    logic              rvalid1_r;
    logic              busy_r;
    logic [DATA_W-1:0] rdata_r;

    logic              gnt0_next_s;
    logic              gnt1_next_s;
    logic              rvalid0_next_s;
    logic              rvalid1_next_s;

    logic              rom_en_s;
    logic [DATA_W-1:0] rom_data_s;

    rom32x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk      (clk),
        .en       (rom_en_s),
        .addr     (addr_r),
        .data_out (rom_data_s)
    );

    // Next-state, latch and output-pulse decode for the arbiter FSM.
    always_comb begin
        state_next_s   = state_r;
        id_next_s      = id_r;
        addr_next_s    = addr_r;
        ptr_next_s     = ptr_r;
        win_s          = REQ_ID_0;
        gnt0_next_s    = 1'b0;
        gnt1_next_s    = 1'b0;
        rvalid0_next_s = 1'b0;
        rvalid1_next_s = 1'b0;
        rom_en_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    // A lone request wins outright; a tie goes to the pointer.
                    if (req0 && req1) begin
                        win_s = ptr_r;
                    end else if (req1) begin
                        win_s = REQ_ID_1;
                    end else begin
                        win_s = REQ_ID_0;
                    end
                    id_next_s    = win_s;
                    addr_next_s  = (win_s == REQ_ID_1) ? addr1 : addr0;
                    ptr_next_s   = other_id(win_s);
                    // The grant register loads now so the pulse lands in READ.
                    gnt0_next_s  = (win_s == REQ_ID_0);
                    gnt1_next_s  = (win_s == REQ_ID_1);
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ: begin
                rom_en_s       = 1'b1;
                // The response register loads now so the pulse lands in RESP.
                rvalid0_next_s = (id_r == REQ_ID_0);
                rvalid1_next_s = (id_r == REQ_ID_1);
                state_next_s   = RESP;
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, round-robin pointer and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= REQ_ID_0;
            id_r    <= REQ_ID_0;
            addr_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
            id_r    <= id_next_s;
            addr_r  <= addr_next_s;
        end
    end

    // Registered handshake outputs and the held copy of the last read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            busy_r    <= 1'b0;
            rdata_r   <= {DATA_W{1'b0}};
        end else begin
            gnt0_r    <= gnt0_next_s;
            gnt1_r    <= gnt1_next_s;
            rvalid0_r <= rvalid0_next_s;
            rvalid1_r <= rvalid1_next_s;
            busy_r    <= (state_next_s != IDLE);
            if (state_r == RESP) begin
                rdata_r <= rom_data_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign gnt0    = gnt0_r;
    assign gnt1    = gnt1_r;
    assign rvalid0 = rvalid0_r;
    assign rvalid1 = rvalid1_r;
    assign busy    = busy_r;
    // In RESP the ROM register already holds the fresh word, so it is shown
    // alongside rvalid; afterwards the captured copy keeps it stable.
    assign rdata   = (state_r == RESP) ? rom_data_s : rdata_r;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: the stimulus side runs a transaction-level
// model and queues expected gnt/rvalid events; a monitor compares DUT pulses.
module tb_rom_arbiter;
    import rom_arbiter_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [AW-1:0] addr0 = 5'd0;
    logic [AW-1:0] addr1 = 5'd0;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata;

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];

    int n_chk = 0;
    int n_fail = 0;

    // model state
    int free_edge = 0;
    int ptr_m = 0;
    int busy_lo = 0;
    int busy_hi = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs and let the model decide whether the arbiter,
    // idle at that edge, accepts a request.
    task automatic step(input logic r0, input logic [AW-1:0] a0,
                        input logic r1, input logic [AW-1:0] a1, output int win);
        int s;
        int av;
        @(negedge clk);
        rst = 1'b0;
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
        s = cyc + 1;
        win = -1;
        if (s >= free_edge && (r0 || r1)) begin
            if (r0 && r1) win = ptr_m;
            else win = r1 ? 1 : 0;
            ptr_m = 1 - win;
            av = (win == 0) ? int'(a0) : int'(a1);
            gq.push_back('{s, win, 8'd0});
            rq.push_back('{s + 1, win, DW'((av + 1) % (1 << DW))});
            busy_lo = s;
            busy_hi = s + 2;
            free_edge = s + 3;
        end
    endtask

    task automatic idle(input int n);
        int w;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 5'd0, w);
    endtask

    // Hold reset for n edges; anything the model expected from then on is void.
    task automatic apply_reset(input int n);
        int e;
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        e = cyc + 1;
        for (int i = gq.size() - 1; i >= 0; i--) if (gq[i].cyc >= e) gq.delete(i);
        for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].cyc >= e) rq.delete(i);
        if (busy_hi > e) busy_hi = e;
        free_edge = 0;
        ptr_m = 0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Monitor: compares every DUT output against the queued expectations.
    logic [DW-1:0] hold_m = 8'd0;
    exp_t ev;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("gnt_exclusive", longint'(gnt0 & gnt1), 0);
            check("rvalid_exclusive", longint'(rvalid0 & rvalid1), 0);
            check("busy", longint'(busy), (cyc >= busy_lo && cyc < busy_hi) ? 1 : 0);
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL gnt_missed: got none expected id %0d at cycle %0d", gq[0].id, gq[0].cyc);
                void'(gq.pop_front());
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL rvalid_missed: got none expected id %0d at cycle %0d", rq[0].id, rq[0].cyc);
                void'(rq.pop_front());
            end
            if (gnt0 || gnt1) begin
                if (gq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL gnt_unexpected: got gnt0=%0d gnt1=%0d expected none at cycle %0d", gnt0, gnt1, cyc);
                end else begin
                    ev = gq.pop_front();
                    check("gnt_cycle", cyc, ev.cyc);
                    check("gnt_id", gnt1 ? 1 : 0, ev.id);
                end
            end
            if (rst) hold_m = 8'd0;
            if (rvalid0 || rvalid1) begin
                if (rq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rvalid_unexpected: got rvalid0=%0d rvalid1=%0d expected none at cycle %0d", rvalid0, rvalid1, cyc);
                end else begin
                    ev = rq.pop_front();
                    check("rvalid_cycle", cyc, ev.cyc);
                    check("rvalid_id", rvalid1 ? 1 : 0, ev.id);
                    check("rdata", longint'(rdata), longint'(ev.data));
                    hold_m = ev.data;
                end
            end else begin
                check("rdata_hold", longint'(rdata), longint'(hold_m));
            end
        end
    end

    // Stimulus
    initial begin
        int w;
        int d0, d1, n1;
        logic          r [2];
        logic [AW-1:0] a [2];
        int            last_w;

        apply_reset(3);

        // Single request, address 5
        step(1'b1, 5'd5, 1'b0, 5'd0, w);
        idle(5);

        // Both requesting right after reset: 0 first, then 1
        apply_reset(2);
        d0 = 0; d1 = 0;
        for (int i = 0; i < 10; i++) begin
            step(d0 == 0, 5'd3, d1 == 0, 5'd31, w);
            if (w == 0) d0 = 1;
            if (w == 1) d1 = 1;
        end
        idle(3);

        // Both held for 12 cycles: alternating grants
        for (int i = 0; i < 12; i++) step(1'b1, 5'd10, 1'b1, 5'd20, w);
        idle(5);

        // Requester 1 back-to-back: address 0 then 7
        n1 = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'd0, n1 < 2, (n1 == 0) ? 5'd0 : 5'd7, w);
            if (w == 1) n1++;
        end
        idle(3);

        // Reset while in READ after a completed read left rdata non-zero
        step(1'b1, 5'd12, 1'b0, 5'd0, w);
        idle(4);
        step(1'b1, 5'd4, 1'b0, 5'd0, w);
        apply_reset(1);
        idle(4);

        // Address changed during READ is ignored
        step(1'b1, 5'd2, 1'b0, 5'd0, w);
        step(1'b0, 5'd9, 1'b0, 5'd0, w);
        idle(4);

        // Randomized traffic with occasional resets
        r[0] = 1'b0; r[1] = 1'b0; a[0] = 5'd0; a[1] = 5'd0; last_w = -1;
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (last_w == k) begin
                    r[k] = 1'($urandom_range(0, 1));
                    a[k] = AW'($urandom_range(0, 31));
                end else if (!r[k]) begin
                    a[k] = AW'($urandom_range(0, 31));
                    if ($urandom_range(0, 2) == 0) r[k] = 1'b1;
                end
            end
            if ($urandom_range(0, 99) == 0) begin
                apply_reset(1 + $urandom_range(0, 2));
                r[0] = 1'b0; r[1] = 1'b0; last_w = -1;
            end else begin
                step(r[0], a[0], r[1], a[1], w);
                last_w = w;
            end
        end
        idle(6);

        check("gnt_queue_drained", gq.size(), 0);
        check("rvalid_queue_drained", rq.size(), 0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
